// File: rtl/branch_hazard_unit_if.sv
// Issue/resolve handshake and status bundle for branch_hazard_unit.
// master drives the instruction stream; slave is the hazard unit.
interface branch_hazard_unit_if #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [OPW-1:0]   opcode_in;
    logic             issue_valid;
    logic             pipe_advance;
    logic             resolve_taken;
    logic             stall;
    logic             flush;
    logic [DEPTH-1:0] branch_vec;
    logic [CW-1:0]    inflight_cnt;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output opcode_in, issue_valid, pipe_advance, resolve_taken,
        input  stall, flush, branch_vec, inflight_cnt, stall_cycles
    );

    modport slave (
        input  opcode_in, issue_valid, pipe_advance, resolve_taken,
        output stall, flush, branch_vec, inflight_cnt, stall_cycles
    );
endinterface

// File: rtl/branch_hazard_unit.sv
// Tracks in-flight branches through a DEPTH-stage shadow, stalls fetch and
// pulses flush on taken retirement. Define BRANCH_STATS_EN to add the stall counter.
module branch_hazard_unit #(
    parameter int unsigned   OPW    = 6,
    parameter int unsigned   DEPTH  = 3,
    parameter logic [OPW-1:0] BEQ_OP = OPW'(6'b000100),
    parameter logic [OPW-1:0] J_OP   = OPW'(6'b000010),
    parameter int unsigned   CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_hazard_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHADOW = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] jump_q, jump_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_jump_c, is_branch_c, retire_taken_c;
    logic             stall_c, flush_c;

    // Opcode decode of the instruction entering stage 0
    always_comb begin
        is_jump_c   = bus.issue_valid && (bus.opcode_in == J_OP);
        is_branch_c = bus.issue_valid && ((bus.opcode_in == BEQ_OP) || (bus.opcode_in == J_OP));
    end

    // State register plus stage shift register and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            jump_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            jump_q  <= jump_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a taken retirement beats any same-edge insertion
    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        jump_d         = jump_q;
        retire_taken_c = valid_q[DEPTH-1] && (jump_q[DEPTH-1] || bus.resolve_taken);
        unique case (state_q)
            FLUSH: begin
                state_d = IDLE;
                valid_d = '0;
                jump_d  = '0;
            end
            default: begin
                if (bus.pipe_advance) begin
                    if (retire_taken_c) begin
                        state_d = FLUSH;
                        valid_d = '0;
                        jump_d  = '0;
                    end else begin
                        for (int i = DEPTH - 1; i > 0; i--) begin
                            valid_d[i] = valid_q[i-1];
                            jump_d[i]  = jump_q[i-1];
                        end
                        valid_d[0] = is_branch_c;
                        jump_d[0]  = is_jump_c;
                        state_d    = (|valid_d) ? SHADOW : IDLE;
                    end
                end
            end
        endcase
    end

    // Population count of the next stage vector, registered with it
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CW'(valid_d[i]);
        end
    end

    // Moore decode of the registered state
    always_comb begin
        stall_c = 1'b0;
        flush_c = 1'b0;
        unique case (state_q)
            SHADOW:  stall_c = 1'b1;
            FLUSH: begin
                stall_c = 1'b1;
                flush_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_c;
    assign bus.branch_vec   = valid_q;
    assign bus.inflight_cnt = cnt_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of edges seen while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`else
    assign bus.stall_cycles = CNT_W'(0);
`endif

endmodule
